// File: rtl/gpio_in_pkg.sv
// rtl/gpio_in_pkg.sv - register offsets and read FSM states for gpio_in_reader
package gpio_in_pkg;

    localparam logic [3:0] GPIO_IN_LEVEL = 4'h0;
    localparam logic [3:0] GPIO_IN_RISE  = 4'h4;
    localparam logic [3:0] GPIO_IN_FALL  = 4'h8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } gpio_in_state_e;

    // Register index from a byte offset; only bits [3:2] select a register.
    function automatic logic [1:0] gpio_in_word(input logic [3:0] offset);
        return offset[3:2];
    endfunction

endpackage

// File: rtl/gpio_in_reader_if.sv
// rtl/gpio_in_reader_if.sv - single-outstanding req/gnt/rvalid read port
interface gpio_in_reader_if;

    logic        rd_req_i;
    logic [3:0]  rd_addr_i;
    logic        rd_gnt_o;
    logic        rd_rvalid_o;
    logic [31:0] rd_rdata_o;

    modport master (
        output rd_req_i,
        output rd_addr_i,
        input  rd_gnt_o,
        input  rd_rvalid_o,
        input  rd_rdata_o
    );

    modport slave (
        input  rd_req_i,
        input  rd_addr_i,
        output rd_gnt_o,
        output rd_rvalid_o,
        output rd_rdata_o
    );

endinterface

// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - one-bit 2-flop synchroniser plus debounce counter
// Counter is built only with GPIO_IN_DEBOUNCE_EN; otherwise stable = synchronised value.
module gpio_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_5mhz,
    input  logic rst_ni,
    input  logic i_raw,
    output logic o_stable
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_param
        $error("gpio_in_debounce: DEBOUNCE_CYCLES out of range 1..2^20");
    end

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // Any cycle that agrees with the stable value restarts the count.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_stable = r_stable;
`else
    assign o_stable = r_sync2;
`endif

endmodule

// File: rtl/gpio_in_reader.sv
// rtl/gpio_in_reader.sv - debounced BTN/SW levels with sticky edge flags and irq
// Debounce depth selected by GPIO_IN_DEBOUNCE_EN (see gpio_in_debounce).
module gpio_in_reader
    import gpio_in_pkg::*;
#(
    parameter int NUM_IN          = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk_5mhz,
    input  logic              rst_ni,
    input  logic [3:0]        btn_i,
    input  logic [3:0]        sw_i,
    gpio_in_reader_if.slave   rd,
    output logic              irq_o
);

    localparam logic [1:0] W_LEVEL = gpio_in_word(GPIO_IN_LEVEL);
    localparam logic [1:0] W_RISE  = gpio_in_word(GPIO_IN_RISE);
    localparam logic [1:0] W_FALL  = gpio_in_word(GPIO_IN_FALL);

    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] w_stable;
    logic [NUM_IN-1:0] r_stable_prev;
    logic [NUM_IN-1:0] r_rise;
    logic [NUM_IN-1:0] r_fall;
    logic [NUM_IN-1:0] w_clr_rise;
    logic [NUM_IN-1:0] w_clr_fall;
    logic [31:0]       w_rd_word;
    logic [31:0]       r_rdata;
    logic              r_irq;
    logic              w_gnt;
    logic              w_rvalid;
    logic              w_capture;
    logic [1:0]        w_word;

    gpio_in_state_e r_state;
    gpio_in_state_e w_state_d;

    assign w_raw  = NUM_IN'({sw_i, btn_i});
    assign w_word = rd.rd_addr_i[3:2];

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bit
        gpio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_5mhz (clk_5mhz),
            .rst_ni   (rst_ni),
            .i_raw    (w_raw[gi]),
            .o_stable (w_stable[gi])
        );
    end

    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_gnt     = 1'b0;
        w_rvalid  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt = rd.rd_req_i;
                if (rd.rd_req_i) begin
                    w_capture = 1'b1;
                    w_state_d = RESP;
                end
            end
            RESP: begin
                w_rvalid  = 1'b1;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_rd_word  = '0;
        w_clr_rise = '0;
        w_clr_fall = '0;
        case (w_word)
            W_LEVEL: w_rd_word = 32'(w_stable);
            W_RISE: begin
                w_rd_word  = 32'(r_rise);
                w_clr_rise = w_capture ? r_rise : '0;
            end
            W_FALL: begin
                w_rd_word  = 32'(r_fall);
                w_clr_fall = w_capture ? r_fall : '0;
            end
            default: w_rd_word = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a coincident event survives the read.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stable_prev <= '0;
            r_rise        <= '0;
            r_fall        <= '0;
            r_irq         <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_stable_prev <= w_stable;
            r_rise        <= (r_rise & ~w_clr_rise) | (w_stable & ~r_stable_prev);
            r_fall        <= (r_fall & ~w_clr_fall) | (~w_stable & r_stable_prev);
            r_irq         <= |{r_rise, r_fall};
            if (w_capture) r_rdata <= w_rd_word;
        end
    end

    assign rd.rd_gnt_o    = w_gnt;
    assign rd.rd_rvalid_o = w_rvalid;
    assign rd.rd_rdata_o  = w_rvalid ? r_rdata : '0;
    assign irq_o          = r_irq;

endmodule

// File: doc/gpio_in_reader.md
# gpio_in_reader

Read-side counterpart of the core-driven `jd` output port. It samples the board's `BTN[3:0]` and `SW[3:0]` inputs and synchronises them into `clk_5mhz`, debounces them, and records rising and falling edges in sticky flags. The core reads the levels and flags over a single-outstanding req/gnt/rvalid port. It sits in the FPGA top beside `cv32e40x_tb_wrapper` and is decoded from the wrapper's data bus.

## Interface
Parameters:
- `NUM_IN`, 8: number of input bits; bits [3:0] = `BTN`, bits [7:4] = `SW`.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a change (10 ms at 5 MHz). Legal range 1..2^20.

Ports (name, direction, width, meaning):
- `clk_5mhz` in 1: system clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `btn_i` in 4: raw push buttons, asynchronous.
- `sw_i` in 4: raw slide switches, asynchronous.
- `rd_req_i` in 1: read request from the core.
- `rd_addr_i` in 4: byte offset; only bits [3:2] are decoded.
- `rd_gnt_o` out 1: request accepted.
- `rd_rvalid_o` out 1: response data valid.
- `rd_rdata_o` out 32: response data.
- `irq_o` out 1: registered; high while any rise or fall flag is set.

## Operation
- Synchroniser: 2-flop chain per input bit. The chain resets to 0.
- Debounce, per bit:
  - A counter counts while the synchronised value differs from the stable value.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable value takes the synchronised value and the counter clears.
  - Any cycle where the synchronised value equals the stable value clears the counter. A glitch shorter than `DEBOUNCE_CYCLES` therefore never propagates.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Edge flags:
  - A stable 0→1 transition sets `rise[i]`.
  - A stable 1→0 transition sets `fall[i]`.
  - Flags stay set until read.
- Register map (`rd_addr_i[3:2]`):
  - 0 = LEVEL `{24'b0, stable}`.
  - 1 = RISE `{24'b0, rise}`, clear-on-read.
  - 2 = FALL `{24'b0, fall}`, clear-on-read.
  - 3 = returns `32'h0`.
- Read FSM has two states, IDLE and RESP:
  - IDLE: `rd_gnt_o = rd_req_i`. When `rd_req_i` is high, capture the data, apply clear-on-read, and go to RESP.
  - RESP: `rd_rvalid_o = 1`, `rd_gnt_o = 0`, `rd_rdata_o` = captured value. Return to IDLE unconditionally.
- Clear-on-read clears only the bits that were captured in the response.
- If a new edge sets a flag in the same cycle that a read clears it, the set wins. No event is lost.

## Timing
- Reset values: all outputs 0, FSM = IDLE, stable = 0, flags = 0, counters = 0.
- Reset asserted mid-response drops `rd_rvalid_o` asynchronously. Any pending response is discarded.
- Raw input change to updated LEVEL: 2 + `DEBOUNCE_CYCLES` + 1 cycles, provided the input holds steady throughout.
- Stable transition to flag set: 1 cycle.
- Flag set to `irq_o` high: 1 cycle.
- Read latency: gnt in cycle N, `rd_rvalid_o` in cycle N+1. Maximum throughput is one read every 2 cycles.
- `rd_rdata_o` holds 0 whenever `rd_rvalid_o` is low.
- Inputs asserted after reset release are flagged as rise events once they are debounced.

## Configuration
- `GPIO_IN_DEBOUNCE_EN` defined: debounce counters are instantiated as described above.
- Not defined: stable value = synchronised value, taken directly with 0 extra cycles. The `DEBOUNCE_CYCLES` parameter is ignored, and edge flags follow the synchronised value.
- All other behaviour is identical in both builds.

## Structure
- Package `gpio_in_pkg` holds:
  - the offset constants `GPIO_IN_LEVEL`, `GPIO_IN_RISE` and `GPIO_IN_FALL`;
  - the enum `gpio_in_state_e` with values IDLE and RESP.
- Sub-module `gpio_in_debounce`: one bit containing the synchroniser, the debounce counter and the stable output. It is generated `NUM_IN` times.
- Top level `gpio_in_reader`: holds the flags, the read FSM and the irq register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- `btn_i` = 4'b0001 held 10 cycles, then read offset 0x0 → `rd_rdata_o` = 32'h01, with `rd_rvalid_o` exactly one cycle after `rd_gnt_o`.
- A 3-cycle pulse on `sw_i[2]` → LEVEL stays 32'h00, RISE stays 32'h00, `irq_o` stays 0.
- Press then release `btn_i[3]` (each held 8 cycles) → RISE reads 32'h08 and FALL reads 32'h08. A second read of each returns 32'h00, and `irq_o` falls 1 cycle after the last clear.
- A debounced rise on `btn_i[1]` lands in the same cycle as a RISE read → that read returns the prior flags, and the next RISE read returns 32'h02.
- `rd_req_i` held high for 6 cycles → `rd_gnt_o` pattern 1,0,1,0,1,0 and `rd_rvalid_o` 0,1,0,1,0,1. Offset 0xC returns 32'h0.
- `rst_ni` pulled low in the RESP cycle → `rd_rvalid_o` = 0 immediately. After release, LEVEL, flags and `irq_o` are all 0.
